// File: rtl/arith_pkg.sv
// Shared arithmetic-family definitions: serial-FSM state encoding and default datapath width.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  // 2'b11 is deliberately left unnamed; the FSM treats it as a recoverable illegal code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/fulladder_cell.sv
// Single-bit combinational full adder used as the serial adder's only arithmetic element.
module fulladder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_sf.sv
// Bit-serial ripple adder: one full-adder cell plus a carry FF resolve one bit per clock, LSB first.
module serial_adder_sf
  import arith_pkg::*;
#(
  parameter  int WIDTH = ARITH_WIDTH,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sra, srb, srs;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_msb, b_msb;
  logic             accept, last_bit;
  logic             fa_s, fa_c;

  fulladder_cell u_fa (
    .a    (sra[0]),
    .b    (srb[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign busy     = (state == ST_SHIFT);
  assign done     = (state == ST_DONE);
  assign last_bit = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = ST_IDLE;
    accept    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: state_nxt = last_bit ? ST_DONE : ST_SHIFT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sra   <= '0;
      srb   <= '0;
      srs   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sra   <= a;
        srb   <= b;
        carry <= cin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (state == ST_SHIFT) begin
        sra   <= sra >> 1;
        srb   <= srb >> 1;
        srs   <= {fa_s, srs[WIDTH-1:1]};
        carry <= fa_c;
        cnt   <= cnt + 1'b1;
      end
      // Results are captured straight from the cell on the final bit, so they only change on DONE entry.
      if (last_bit) begin
        s    <= {fa_s, srs[WIDTH-1:1]};
        cout <= fa_c;
        ovf  <= (a_msb == b_msb) && (fa_s != a_msb);
      end
    end
  end

endmodule

// File: doc/serial_adder_sf.md
Name: serial_adder_sf

Overview:
- Bit-serial N-bit ripple adder; the additive counterpart of the team's full-subtractor cells.
- Loads two operands plus carry-in on a start pulse and resolves one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Presents sum, carry-out and signed overflow with a one-cycle done strobe.
- Used wherever area matters more than latency in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request pulse; sampled only when idle or done.
- a  input  WIDTH  augend; sampled on accepted start.
- b  input  WIDTH  addend; sampled on accepted start.
- cin  input  1  carry-in; sampled on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle strobe; result valid.
- s  output  WIDTH  sum a+b+cin (mod 2^WIDTH), held until next accepted start.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow: (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]).

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE. busy=0, done=0, s=0, cout=0, ovf=0. Internal shift registers, carry FF and counter all cleared. Takes effect mid-operation; the operation is abandoned and no done is issued.
- States:
  - IDLE: start=1 -> latch a->sra, b->srb, cin->carry, cnt=0; go to SHIFT.
  - SHIFT: busy=1. Each cycle, the full-adder cell computes from sra[0], srb[0] and carry:
    - sum bit = sra[0]^srb[0]^carry, shifted into srs[WIDTH-1] (srs shifts right);
    - carry <= majority(sra[0], srb[0], carry);
    - sra and srb shift right; cnt++.
    - When cnt==WIDTH-1 in SHIFT, go to DONE.
  - DONE: done=1 for exactly this cycle. s=srs, cout=carry. ovf is computed from the latched operand MSBs, which are kept in two dedicated FFs captured at start.
    - start=1 here -> accepted exactly as from IDLE (back-to-back, no bubble); go to SHIFT.
    - Otherwise go to IDLE.
- Latency: start accepted at edge k -> done high in the cycle following edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- s, cout and ovf update only on entry to DONE. They are stable in IDLE and SHIFT and are not glitched by the shift process.
- start while in SHIFT is ignored; no queuing, no error flag.
- Inputs a, b and cin are don't-care except on the accepting edge.
- Arithmetic: unsigned sum modulo 2^WIDTH. cout is the (WIDTH+1)th bit. ovf is valid for two's-complement interpretation.
- State encoding: binary, 2 bits; value 2'b11 is illegal and recovers to IDLE on the next edge.

Decomposition:
- Shared package arith_pkg holds:
  - state typedef/localparams ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_DONE=2'b10;
  - the default WIDTH constant, shared with the subtractor family.
- One natural sub-module: fulladder_cell (combinational a, b, cin -> sum, cout), instantiated once. The FSM, shift registers and counter stay in serial_adder_sf.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start 1 cycle -> busy for 8 cycles, done in the 9th cycle, s=0x7F, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1, ovf=0; then a=0x7F, b=0x01 -> s=0x80, cout=0, ovf=1; then a=0x80, b=0x80, cin=1 -> s=0x01, cout=1, ovf=1.
- Start held high continuously with new operands presented in each DONE cycle (0x10+0x20, 0x03+0x04) -> done every 9 cycles, results 0x30 then 0x07, no idle bubble.
- Start pulsed again 3 cycles into SHIFT with different operands -> ignored; original result delivered at the original done cycle.
- rst_n low for 1 cycle at SHIFT cycle 4 -> next cycle busy=0, done=0, s=0, cout=0, ovf=0; no done follows; the next start completes normally.
- Random sweep of 1000 operand/cin triples vs. a reference a+b+cin model -> s, cout and ovf match exactly; done always exactly 1 cycle wide.
